// File: rtl/pipe_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_chk_pkg : shared defaults and reference sum for the 3-op adder   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pipe_chk_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_CNT_W   = 16;

    function automatic logic [DEF_W-1:0] sum3(
        input logic [DEF_W-1:0] a,
        input logic [DEF_W-1:0] b,
        input logic [DEF_W-1:0] c
    );
        logic [DEF_W+1:0] s;
        s = {2'b00, a} + {2'b00, b} + {2'b00, c};
        return s[DEF_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/chk_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chk_delay_line : DEPTH-stage shift register of {valid, data}          |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module chk_delay_line #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Payload carries no reset; it is only meaningful alongside its valid bit.
    always_ff @(posedge clk) begin
        r_data[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) begin
            r_data[i] <= r_data[i-1];
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pipe_sum_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_sum_checker : scoreboard for the pipelined 3-operand adder       |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_sum_checker
    import pipe_chk_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     z,
    input  logic             clr_stats,
    output logic             cmp_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             error,
    output logic [W-1:0]     exp_first,
    output logic [W-1:0]     got_first
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [W-1:0]     w_exp;
    logic             w_dl_valid;
    logic [W-1:0]     w_dl_exp;
    logic             w_miss;

    logic             r_cmp_valid;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_error;
    logic [W-1:0]     r_exp_first;
    logic [W-1:0]     r_got_first;

    generate
        if (W == DEF_W) begin : g_sum_pkg
            assign w_exp = sum3(a, b, c);
        end else begin : g_sum_local
            logic [W+1:0] w_sum_wide;
            assign w_sum_wide = {2'b00, a} + {2'b00, b} + {2'b00, c};
            assign w_exp      = w_sum_wide[W-1:0];
        end
    endgenerate

    chk_delay_line #(
        .DEPTH  (LATENCY),
        .DATA_W (W)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .i_data  (w_exp),
        .o_valid (w_dl_valid),
        .o_data  (w_dl_exp)
    );

    assign w_miss = w_dl_valid && (z != w_dl_exp);

    // Pulses always follow the delay line; clr_stats only affects the statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_valid <= 1'b0;
            r_mismatch  <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_error     <= 1'b0;
            r_exp_first <= '0;
            r_got_first <= '0;
        end else begin
            r_cmp_valid <= w_dl_valid;
            r_mismatch  <= w_miss;
            if (clr_stats) begin
                r_pass_cnt  <= '0;
                r_fail_cnt  <= '0;
                r_error     <= 1'b0;
                r_exp_first <= '0;
                r_got_first <= '0;
            end else if (w_dl_valid) begin
                if (w_miss) begin
                    if (r_fail_cnt != c_CNT_MAX) begin
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                    end
                    if (!r_error) begin
                        r_error     <= 1'b1;
                        r_exp_first <= w_dl_exp;
                        r_got_first <= z;
                    end
                end else if (r_pass_cnt != c_CNT_MAX) begin
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                end
            end
        end
    end

    assign cmp_valid = r_cmp_valid;
    assign mismatch  = r_mismatch;
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign error     = r_error;
    assign exp_first = r_exp_first;
    assign got_first = r_got_first;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sum_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_sum_checker : directed + random bench for pipe_sum_checker    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pipe_sum_checker;

    localparam int L     = 2;
    localparam int NHIST = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        clr_stats = 1'b0;
    logic [7:0]  a = '0, b = '0, c = '0, z = '0;

    logic        cmp_valid, mismatch, error;
    logic [15:0] pass_cnt, fail_cnt;
    logic [7:0]  exp_first, got_first;
    logic        s_cmp_valid, s_mismatch, s_error;
    logic [3:0]  s_pass_cnt, s_fail_cnt;
    logic [7:0]  s_exp_first, s_got_first;

    always #5 clk = ~clk;

    pipe_sum_checker #(.W(8), .LATENCY(L), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .z(z),
        .clr_stats(clr_stats), .cmp_valid(cmp_valid), .mismatch(mismatch),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .error(error),
        .exp_first(exp_first), .got_first(got_first)
    );

    pipe_sum_checker #(.W(8), .LATENCY(L), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .z(z),
        .clr_stats(clr_stats), .cmp_valid(s_cmp_valid), .mismatch(s_mismatch),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .error(s_error),
        .exp_first(s_exp_first), .got_first(s_got_first)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rst = -1;

    // Per-cycle history of what was presented to the adder.
    int hv     [NHIST];
    int hexp   [NHIST];
    int hfault [NHIST];
    int hfz    [NHIST];

    int m_cmpv, m_mis, m_pass, m_fail, m_pass_s, m_fail_s, m_err, m_ef, m_gf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic step(input logic r, input logic cl, input logic v,
                        input int av, input int bv, input int cv,
                        input logic flt, input int fz);
        int n;
        @(negedge clk);
        rst       = r;
        clr_stats = cl;
        in_valid  = v;
        a = av[7:0];
        b = bv[7:0];
        c = cv[7:0];
        hv[cyc]     = int'(v);
        hexp[cyc]   = (av + bv + cv) % 256;
        hfault[cyc] = int'(flt);
        hfz[cyc]    = fz % 256;
        n = cyc - L;
        // Behaves as a correct adder unless this result was marked faulty.
        if (n >= 0 && hv[n] != 0)
            z = (hfault[n] != 0) ? 8'(hfz[n]) : 8'(hexp[n]);
        else
            z = 8'($urandom);
        @(posedge clk);
        #1;
        if (r) begin
            m_cmpv = 0; m_mis = 0; m_pass = 0; m_fail = 0; m_pass_s = 0; m_fail_s = 0;
            m_err = 0; m_ef = 0; m_gf = 0;
            last_rst = cyc;
        end else begin
            m_cmpv = (n >= 0 && hv[n] != 0 && last_rst < n) ? 1 : 0;
            m_mis  = (m_cmpv != 0 && int'(z) != hexp[n]) ? 1 : 0;
            if (cl) begin
                m_pass = 0; m_fail = 0; m_pass_s = 0; m_fail_s = 0;
                m_err = 0; m_ef = 0; m_gf = 0;
            end else if (m_cmpv != 0) begin
                if (m_mis != 0) begin
                    m_fail   = sat_inc(m_fail, 65535);
                    m_fail_s = sat_inc(m_fail_s, 15);
                    if (m_err == 0) begin
                        m_err = 1; m_ef = hexp[n]; m_gf = int'(z);
                    end
                end else begin
                    m_pass   = sat_inc(m_pass, 65535);
                    m_pass_s = sat_inc(m_pass_s, 15);
                end
            end
        end
        chk("cmp_valid", cmp_valid, m_cmpv);
        chk("mismatch",  mismatch,  m_mis);
        chk("pass_cnt",  pass_cnt,  m_pass);
        chk("fail_cnt",  fail_cnt,  m_fail);
        chk("error",     error,     m_err);
        chk("exp_first", exp_first, m_ef);
        chk("got_first", got_first, m_gf);
        chk("s_pass_cnt", s_pass_cnt, m_pass_s);
        chk("s_fail_cnt", s_fail_cnt, m_fail_s);
        chk("s_cmp_valid", s_cmp_valid, m_cmpv);
        cyc++;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic op(input int av, input int bv, input int cv);
        step(1'b0, 1'b0, 1'b1, av, bv, cv, 1'b0, 0);
    endtask

    task automatic op_fault(input int av, input int bv, input int cv, input int fz);
        step(1'b0, 1'b0, 1'b1, av, bv, cv, 1'b1, fz);
    endtask

    initial begin
        int av, bv, cv, e;
        logic r, cl, v, f;

        // Reset held for two edges.
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0);

        // Basic single transaction.
        op(1, 2, 3);
        idle(L + 1);
        chk("basic_pass", pass_cnt, 1);

        // Back-to-back stream including wrapping sums.
        op(10, 20, 30);
        op(200, 100, 10);
        op(255, 255, 255);
        op(0, 0, 0);
        op(7, 8, 9);
        idle(L + 1);
        chk("stream_pass", pass_cnt, 6);
        chk("stream_fail", fail_cnt, 0);

        // Two faults; only the first is captured.
        op_fault(1, 2, 3, 7);
        idle(1);
        op_fault(2, 3, 4, 0);
        idle(L + 1);
        chk("fault_fail", fail_cnt, 2);
        chk("fault_err",  error, 1);
        chk("fault_expf", exp_first, 6);
        chk("fault_gotf", got_first, 7);

        // Clear, then saturate the narrow counters.
        step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 20; i++) op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        idle(L + 1);
        chk("sat_narrow", s_pass_cnt, 15);
        chk("sat_wide",   pass_cnt, 20);

        // Clear coinciding with a mismatch comparison.
        op_fault(4, 4, 4, 99);
        idle(L - 1);
        step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
        chk("clr_coll_fail", fail_cnt, 0);
        chk("clr_coll_err",  error, 0);
        idle(L);

        // Reset with two entries in flight.
        op(3, 3, 3);
        op(5, 5, 5);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
        idle(L + 1);
        op(9, 9, 9);
        idle(L + 1);
        chk("post_rst_pass", pass_cnt, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            av = $urandom_range(0, 255);
            bv = $urandom_range(0, 255);
            cv = $urandom_range(0, 255);
            e  = (av + bv + cv) % 256;
            r  = ($urandom_range(0, 99) == 0);
            cl = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 7);
            f  = ($urandom_range(0, 7) == 0);
            step(r, cl, v, av, bv, cv, f, (e + 1 + $urandom_range(0, 254)) % 256);
        end
        idle(L + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
